// File: rtl/hazard_controller.sv
// Issue controller for the decode/execute interface register: tracks in-flight
// destination registers and decides issue / stall / squash each cycle.
module hazard_controller #(
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [4:0]       dec_src1,
  input  logic             dec_src1_use,
  input  logic [4:0]       dec_src2,
  input  logic             dec_src2_use,
  input  logic [4:0]       dec_dst1,
  input  logic             dec_dst1_wr,
  input  logic [4:0]       dec_dst2,
  input  logic             dec_dst2_wr,
  input  logic             mem_busy,
  input  logic             branch_taken,
  output logic             d_pass,
  output logic             d_pcincr,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [4:0]       dbg_state
);

  // Handshake: there is none in the valid/ready sense. d_pass and d_pcincr are
  // decided combinationally each cycle and consumed by the interface register
  // on the same rising edge; the register always advances.

  typedef struct packed {
    logic       v1;
    logic [4:0] a1;
    logic       v2;
    logic [4:0] a2;
  } sb_entry_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sb_entry_t  sb [DEPTH];
  state_t     state, state_nxt;
  logic [3:0] fcnt, fcnt_nxt;
  logic       hazard;
  logic       squash, mstall, hstall;

  assign dbg_state = {state, fcnt};

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (dec_src1_use && sb[i].v1 && (sb[i].a1 == dec_src1)) hazard = 1'b1;
      if (dec_src1_use && sb[i].v2 && (sb[i].a2 == dec_src1)) hazard = 1'b1;
      if (dec_src2_use && sb[i].v1 && (sb[i].a1 == dec_src2)) hazard = 1'b1;
      if (dec_src2_use && sb[i].v2 && (sb[i].a2 == dec_src2)) hazard = 1'b1;
    end
  end

  // Squash outranks memory stall, which outranks hazard stall.
  always_comb begin
    squash   = branch_taken | (state == FLUSH);
    mstall   = !squash & mem_busy;
    hstall   = !squash & !mem_busy & dec_valid & hazard;
    d_pass   = !rst & dec_valid & !squash & !mem_busy & !hazard;
    d_pcincr = rst | !(mstall | hstall);
    stall    = !rst & (mstall | hstall);
    flush    = !rst & squash;
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    if (branch_taken && (FLUSH_CYCLES > 0)) begin
      state_nxt = FLUSH;
      fcnt_nxt  = 4'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH) begin
      if (fcnt == 4'd0) state_nxt = RUN;
      else              fcnt_nxt  = fcnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Shifts every edge; a non-issued cycle inserts an empty entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sb[i] <= '0;
    end else begin
      sb[0] <= d_pass ? {dec_dst1_wr, dec_dst1, dec_dst2_wr, dec_dst2} : '0;
      for (int i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != CNT_MAX))        stall_cnt <= stall_cnt + 1'b1;
      if (branch_taken && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
